// File: rtl/datapath_sequencer.sv
// Control stage for the register-file/ALU datapath: buffers 9-bit micro-instructions
// in a FIFO and issues each one as a two-cycle SETUP/WRITE sequence.
module datapath_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_instr,
    output logic [1:0]       addr1,
    output logic [1:0]       addr2,
    output logic [1:0]       addr3,
    output logic [2:0]       aluControl,
    output logic             wr,
    input  logic [31:0]      result_in,
    output logic [31:0]      last_result,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] issued_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t        state;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // in_ready depends only on registered occupancy (and rst), never on in_valid
    assign in_ready = !rst && !full;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && ((state == IDLE) || (state == WRITE));

    assign wr   = (state == WRITE);
    assign busy = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr1        <= '0;
            addr2        <= '0;
            addr3        <= '0;
            aluControl   <= '0;
            done         <= 1'b0;
            last_result  <= '0;
            issued_count <= '0;
        end else begin
            done <= (state == WRITE);
            if (pop) begin
                {aluControl, addr3, addr2, addr1} <= mem[rptr];
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    state <= WRITE;
                end
                WRITE: begin
                    last_result  <= result_in;
                    issued_count <= issued_count + 1'b1;
                    state        <= pop ? SETUP : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Upstream control stage for the 4-entry x 32-bit register-file/ALU datapath.
- Accepts 9-bit micro-instructions over a valid/ready handshake and buffers them in a small FIFO.
- Issues each instruction as a two-cycle SETUP/WRITE sequence on the datapath's addr1/addr2/addr3/aluControl/wr inputs.
- Captures the datapath's result on every committed write and counts retired instructions.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of issued_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  FIFO can accept.
- in_instr  in  9  [8:6]=aluControl, [5:4]=addr3 (dest), [3:2]=addr2, [1:0]=addr1.
- addr1  out  2  datapath read port 1 address.
- addr2  out  2  datapath read port 2 address.
- addr3  out  2  datapath write address.
- aluControl  out  3  datapath ALU op, passed through unmodified.
- wr  out  1  datapath register write enable.
- result_in  in  32  datapath ALU result.
- last_result  out  32  result_in sampled on the last committed write.
- busy  out  1  high when state is not IDLE or the FIFO is non-empty.
- done  out  1  one-cycle pulse after each committed write.
- issued_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate):
  - State is IDLE and the FIFO is flushed (pointers and occupancy 0).
  - addr1/addr2/addr3/aluControl = 0, wr = 0, done = 0, last_result = 0, issued_count = 0.
  - in_ready = 0 while rst is high.
- Push: occurs on a rising edge with in_valid && in_ready.
  - in_ready = !full, computed from registered occupancy only; no combinational path from in_valid.
  - Push and pop on the same edge are both legal, including when occupancy = DEPTH-1 and when occupancy = DEPTH (pop only, since in_ready = 0).
  - No bypass: a pushed instruction is always popped on a later edge.
- FSM (states IDLE, SETUP, WRITE):
  - IDLE with FIFO non-empty: at the edge, pop the head into the op register and go to SETUP. Otherwise stay in IDLE.
  - SETUP -> WRITE unconditionally. wr = 0; addresses and aluControl are driven from the op register so datapath reads settle.
  - WRITE: wr = 1. At the closing edge:
    - The datapath commits the write.
    - last_result <= result_in.
    - issued_count <= issued_count + 1.
    - done <= 1 for the following cycle.
    - If the FIFO is non-empty, pop the next instruction and go to SETUP; else go to IDLE.
- Outputs:
  - addr1/addr2/addr3/aluControl are registered and change only on a pop edge; they hold their last values while IDLE.
  - wr is decoded from the state register (state == WRITE). It is glitch-free and exactly one cycle wide per instruction.
- Latency: push at edge N -> pop/SETUP at edge N+1 -> WRITE at N+2 -> commit at N+3; done high N+3..N+4.
- Throughput: one instruction per 2 cycles in steady state, with no idle cycle between back-to-back instructions.
- Order: strict FIFO; no instruction is dropped or duplicated.
- issued_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation:
  - wr falls in the same cycle rst rises.
  - Any in-flight instruction is abandoned and not counted.
  - last_result is cleared.

Test Plan:
1. Reset: assert rst for 2 cycles -> all outputs 0, in_ready=0; after release in_ready=1, busy=0.
2. Single op: push {alu=001, addr3=2, addr2=2, addr1=0} at edge N -> addr1=0, addr2=2, addr3=2, aluControl=001 from N+1; wr=1 only between N+2 and N+3; with result_in=32'hFFFF_FFFF, last_result=32'hFFFF_FFFF, issued_count=1, one done pulse.
3. Burst: hold in_valid for 8 distinct instructions with DEPTH=4:
   - in_ready drops low at least once.
   - All 8 are issued in push order.
   - wr pulses every 2 cycles with no gaps; issued_count=8.
4. Simultaneous push/pop: occupancy=3 (DEPTH=4) and the FSM pops on the same edge as a push -> occupancy stays 3 and the pushed entry is issued in order.
5. Reset mid-WRITE: assert rst while wr=1 -> wr=0 immediately; queued entries are discarded; issued_count=0; the next pushed instruction executes normally.
6. Wrap: CNT_W=2, issue 5 instructions -> issued_count=1, with 5 done pulses.
